// File: rtl/daq_pkg.sv
// Shared types and constants for the ADC acquisition path.
package daq_pkg;

    localparam int ADC_WORD_W = 24;
    localparam int SPI_CMD_W  = 8;

    localparam logic [SPI_CMD_W-1:0] CMD_BASE_DEFAULT = 8'h10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DRDY = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        OUTPUT    = 3'd4,
        NEXT      = 3'd5
    } scan_state_t;

endpackage

// File: rtl/adc_scan_sequencer_channel_picker.sv
// Returns the lowest set mask bit strictly above index_i; index_i = -1 yields the lowest set bit.
module channel_picker #(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_W         = 2
) (
    input  logic [NUM_CHANNELS-1:0] mask_i,
    input  logic signed [CH_W:0]    index_i,
    output logic [CH_W-1:0]         next_o,
    output logic                    found_o
);

    // Scan downwards so the last hit is the lowest qualifying bit.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(index_i))) begin
                next_o  = CH_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Walks the enabled ADC channels once per trigger, running one SPI transaction per channel
// and presenting each tagged result on a valid/ready stream.
//
// state     | meaning
// IDLE      | waiting for trigger_i with enable_i
// WAIT_DRDY | waiting for drdy_n_i low, timeout counter running
// START     | one-cycle spi start, command byte driven
// WAIT_DONE | waiting for a spi_done_i rise (low seen since START)
// OUTPUT    | sample_valid_o held until sample_ready_i
// NEXT      | pick the next enabled channel or end the frame
module adc_scan_sequencer
    import daq_pkg::*;
#(
    parameter int                    NUM_CHANNELS = 4,
    parameter int                    CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter logic [SPI_CMD_W-1:0]  CMD_BASE     = CMD_BASE_DEFAULT,
    parameter int                    DRDY_TIMEOUT = 1000
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    trigger_i,
    input  logic [NUM_CHANNELS-1:0] channel_mask_i,
    input  logic                    drdy_n_i,
    output logic                    spi_start_o,
    output logic [SPI_CMD_W-1:0]    spi_tx_buffer_o,
    input  logic                    spi_done_i,
    input  logic [ADC_WORD_W-1:0]   spi_rx_buffer_i,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    output logic [ADC_WORD_W-1:0]   sample_data_o,
    output logic [CH_W-1:0]         sample_channel_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    timeout_o,
    output logic [15:0]             overrun_count_o
);

    localparam int               TMR_W    = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRDY_TIMEOUT - 1);

    scan_state_t             state_q, state_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    seen_low_q, seen_low_d;
    logic [SPI_CMD_W-1:0]    tx_q, tx_d;
    logic [ADC_WORD_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]         sample_ch_q, sample_ch_d;
    logic                    frame_done_q, frame_done_d;
    logic [15:0]             overrun_q, overrun_d;

    logic [NUM_CHANNELS-1:0] pick_mask;
    logic signed [CH_W:0]    pick_index;
    logic [CH_W-1:0]         pick_next;
    logic                    pick_found;
    logic                    busy;

    assign busy = (state_q != IDLE);

    // In IDLE the live mask is searched from the bottom; afterwards the latched mask above the current channel.
    assign pick_mask  = (state_q == IDLE) ? channel_mask_i : mask_q;
    assign pick_index = (state_q == IDLE) ? '1 : $signed({1'b0, ch_q});

    channel_picker #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CH_W         (CH_W)
    ) u_picker (
        .mask_i  (pick_mask),
        .index_i (pick_index),
        .next_o  (pick_next),
        .found_o (pick_found)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            ch_q         <= '0;
            tmr_q        <= '0;
            seen_low_q   <= 1'b0;
            tx_q         <= '0;
            data_q       <= '0;
            sample_ch_q  <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            ch_q         <= ch_d;
            tmr_q        <= tmr_d;
            seen_low_q   <= seen_low_d;
            tx_q         <= tx_d;
            data_q       <= data_d;
            sample_ch_q  <= sample_ch_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        ch_d           = ch_q;
        tmr_d          = tmr_q;
        seen_low_d     = seen_low_q;
        tx_d           = tx_q;
        data_d         = data_q;
        sample_ch_d    = sample_ch_q;
        frame_done_d   = 1'b0;
        overrun_d      = overrun_q;
        spi_start_o    = 1'b0;
        sample_valid_o = 1'b0;
        timeout_o      = 1'b0;

        if (trigger_i && enable_i && busy && (overrun_q != 16'hFFFF)) begin
            overrun_d = overrun_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (trigger_i && enable_i) begin
                    mask_d = channel_mask_i;
                    if (pick_found) begin
                        ch_d    = pick_next;
                        state_d = WAIT_DRDY;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            WAIT_DRDY: begin
                tmr_d = tmr_q + 1'b1;
                if (!drdy_n_i) begin
                    tx_d    = CMD_BASE + SPI_CMD_W'(ch_q);
                    state_d = START;
                end else if (tmr_q == TMR_LAST) begin
                    timeout_o = 1'b1;
                    state_d   = NEXT;
                end
            end
            START: begin
                spi_start_o = 1'b1;
                seen_low_d  = !spi_done_i;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done level left over from the previous transfer is ignored until it drops.
                if (spi_done_i && seen_low_q) begin
                    data_d      = spi_rx_buffer_i;
                    sample_ch_d = ch_q;
                    state_d     = OUTPUT;
                end else if (!spi_done_i) begin
                    seen_low_d = 1'b1;
                end
            end
            OUTPUT: begin
                sample_valid_o = 1'b1;
                if (sample_ready_i) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                tmr_d = '0;
                if (pick_found && enable_i) begin
                    ch_d    = pick_next;
                    state_d = WAIT_DRDY;
                end else begin
                    frame_done_d = enable_i;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign spi_tx_buffer_o  = tx_q;
    assign sample_data_o    = data_q;
    assign sample_channel_o = sample_ch_q;
    assign busy_o           = busy;
    assign frame_done_o     = frame_done_q;
    assign overrun_count_o  = overrun_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a small SPI/ADC responder and DRDY generator.
module tb_adc_scan_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        trigger_i;
    logic [3:0]  channel_mask_i;
    logic        drdy_n_i;
    logic        spi_start_o;
    logic [7:0]  spi_tx_buffer_o;
    logic        spi_done_i;
    logic [23:0] spi_rx_buffer_i;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic [23:0] sample_data_o;
    logic [1:0]  sample_channel_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        timeout_o;
    logic [15:0] overrun_count_o;

    adc_scan_sequencer #(
        .NUM_CHANNELS (4),
        .CMD_BASE     (8'h10),
        .DRDY_TIMEOUT (1000)
    ) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .enable_i         (enable_i),
        .trigger_i        (trigger_i),
        .channel_mask_i   (channel_mask_i),
        .drdy_n_i         (drdy_n_i),
        .spi_start_o      (spi_start_o),
        .spi_tx_buffer_o  (spi_tx_buffer_o),
        .spi_done_i       (spi_done_i),
        .spi_rx_buffer_i  (spi_rx_buffer_i),
        .sample_valid_o   (sample_valid_o),
        .sample_ready_i   (sample_ready_i),
        .sample_data_o    (sample_data_o),
        .sample_channel_o (sample_channel_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o),
        .timeout_o        (timeout_o),
        .overrun_count_o  (overrun_count_o)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drdy_mode = 0;   // 0: drdy low, 1: falls 50 cycles after each request, 2: held high

    int          start_cyc[$];
    logic [7:0]  start_tx[$];
    int          hs_cyc[$];
    logic [1:0]  hs_ch[$];
    logic [23:0] hs_data[$];
    int          fall_cyc[$];
    int          n_done = 0;
    int          done_cyc = 0;
    int          n_to = 0;
    int          to_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tx_at(input int i);
        if (i < start_tx.size()) return 32'(start_tx[i]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] scyc_at(input int i);
        if (i < start_cyc.size()) return 32'(start_cyc[i]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] hcyc_at(input int i);
        if (i < hs_cyc.size()) return 32'(hs_cyc[i]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] ch_at(input int i);
        if (i < hs_ch.size()) return 32'(hs_ch[i]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] data_at(input int i);
        if (i < hs_data.size()) return 32'(hs_data[i]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] fall_at(input int i);
        if (i < fall_cyc.size()) return 32'(fall_cyc[i]);
        return 32'h7FFF_FFFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic pulse_trigger(output int t);
        trigger_i = 1'b1;
        t = cyc;
        tick(1);
        trigger_i = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            tick(1);
            k++;
        end
        check_eq(tag, 32'(n_done >= target), 32'd1);
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clock_i);
            cyc++;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock_i);
            if (spi_start_o) begin
                start_cyc.push_back(cyc);
                start_tx.push_back(spi_tx_buffer_o);
            end
            if (sample_valid_o && sample_ready_i) begin
                hs_cyc.push_back(cyc);
                hs_ch.push_back(sample_channel_o);
                hs_data.push_back(sample_data_o);
            end
            if (frame_done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (timeout_o) begin
                n_to++;
                to_cyc = cyc;
            end
        end
    end

    // SPI/ADC responder: done stays high (stale) for two cycles after start, then low, then high with data.
    initial begin : spi_model
        int cnt;
        logic [7:0] cmd;
        cnt = 0;
        cmd = 8'h00;
        spi_done_i = 1'b0;
        spi_rx_buffer_i = 24'h0;
        forever begin
            @(posedge clock_i);
            #1;
            if (spi_start_o) begin
                cmd = spi_tx_buffer_o;
                cnt = 6;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 4) spi_done_i = 1'b0;
                if (cnt == 0) begin
                    spi_done_i = 1'b1;
                    spi_rx_buffer_i = 24'hDECA00 + 24'(cmd - 8'h10);
                end
            end
        end
    end

    initial begin : drdy_model
        int dly;
        logic prev_busy;
        dly = 0;
        prev_busy = 1'b0;
        drdy_n_i = 1'b0;
        forever begin
            @(posedge clock_i);
            #1;
            case (drdy_mode)
                0: begin
                    drdy_n_i = 1'b0;
                    dly = 0;
                end
                2: begin
                    drdy_n_i = 1'b1;
                    dly = 0;
                end
                default: begin
                    if (spi_start_o) drdy_n_i = 1'b1;
                    if ((busy_o && !prev_busy) || sample_valid_o) begin
                        drdy_n_i = 1'b1;
                        dly = 50;
                    end else if (dly > 0) begin
                        dly--;
                        if (dly == 0) begin
                            drdy_n_i = 1'b0;
                            fall_cyc.push_back(cyc);
                        end
                    end
                end
            endcase
            prev_busy = busy_o;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t, tx, sb, hb, fb, nd, nt, k;
        logic ok;

        reset_i = 1'b1;
        enable_i = 1'b1;
        trigger_i = 1'b0;
        channel_mask_i = 4'b0000;
        sample_ready_i = 1'b1;
        drdy_mode = 0;
        tick(3);
        check_eq("rst_ctrl", {27'd0, spi_start_o, busy_o, sample_valid_o, frame_done_o, timeout_o}, 32'd0);
        check_eq("rst_tx", spi_tx_buffer_o, 32'd0);
        check_eq("rst_sample", {sample_channel_o, sample_data_o}, 32'd0);
        check_eq("rst_overrun", overrun_count_o, 32'd0);
        reset_i = 1'b0;
        tick(2);

        // All four channels, drdy always low.
        channel_mask_i = 4'b1111;
        sb = start_cyc.size(); hb = hs_cyc.size(); nd = n_done;
        pulse_trigger(t);
        wait_frames(nd + 1, 200, "t1_frame_done");
        check_eq("t1_nstart", start_cyc.size() - sb, 32'd4);
        check_eq("t1_nsample", hs_cyc.size() - hb, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_tx", tx_at(sb + i), 32'h10 + i);
            check_eq("t1_ch", ch_at(hb + i), i);
            check_eq("t1_data", data_at(hb + i), 32'hDECA00 + i);
        end
        check_eq("t1_lat_start", scyc_at(sb), t + 2);
        check_eq("t1_lat_valid", hcyc_at(hb), scyc_at(sb) + 7);
        check_eq("t1_lat_next", scyc_at(sb + 1), hcyc_at(hb) + 3);
        check_eq("t1_done_cyc", done_cyc, hcyc_at(hb + 3) + 2);
        check_eq("t1_ndone", n_done - nd, 32'd1);
        tick(3);

        // Sparse mask, drdy falls 50 cycles after each request.
        drdy_mode = 1;
        channel_mask_i = 4'b1010;
        sb = start_cyc.size(); hb = hs_cyc.size(); fb = fall_cyc.size(); nd = n_done;
        pulse_trigger(t);
        wait_frames(nd + 1, 400, "t2_frame_done");
        drdy_mode = 0;
        check_eq("t2_nstart", start_cyc.size() - sb, 32'd2);
        check_eq("t2_tx0", tx_at(sb), 32'h11);
        check_eq("t2_tx1", tx_at(sb + 1), 32'h13);
        check_eq("t2_ch0", ch_at(hb), 32'd1);
        check_eq("t2_ch1", ch_at(hb + 1), 32'd3);
        check_eq("t2_data1", data_at(hb + 1), 32'hDECA03);
        check_eq("t2_after_fall0", 32'(scyc_at(sb) >= fall_at(fb) + 1), 32'd1);
        check_eq("t2_after_fall1", 32'(scyc_at(sb + 1) >= fall_at(fb + 1) + 1), 32'd1);
        tick(3);

        // Channel 0 never ready: timeout, then channel 1.
        drdy_mode = 2;
        channel_mask_i = 4'b0011;
        sb = start_cyc.size(); hb = hs_cyc.size(); nd = n_done; nt = n_to;
        pulse_trigger(t);
        k = 0;
        while (n_to == nt && k < 1100) begin
            tick(1);
            k++;
        end
        drdy_mode = 0;
        check_eq("t3_timeout_seen", n_to - nt, 32'd1);
        check_eq("t3_timeout_cyc", to_cyc, t + 1000);
        check_eq("t3_no_ch0_start", start_cyc.size() - sb, 32'd0);
        wait_frames(nd + 1, 100, "t3_frame_done");
        check_eq("t3_ntimeout", n_to - nt, 32'd1);
        check_eq("t3_nstart", start_cyc.size() - sb, 32'd1);
        check_eq("t3_tx", tx_at(sb), 32'h11);
        check_eq("t3_ch", ch_at(hb), 32'd1);
        check_eq("t3_data", data_at(hb), 32'hDECA01);
        tick(3);

        // Back-pressure: ready low for 20 cycles on channel 0.
        sample_ready_i = 1'b0;
        channel_mask_i = 4'b0011;
        sb = start_cyc.size(); hb = hs_cyc.size(); nd = n_done;
        pulse_trigger(t);
        k = 0;
        while (!sample_valid_o && k < 50) begin
            tick(1);
            k++;
        end
        check_eq("t4_valid_seen", sample_valid_o, 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!sample_valid_o || sample_data_o != 24'hDECA00 || sample_channel_o != 2'd0
                || start_cyc.size() != sb + 1) ok = 1'b0;
            tick(1);
        end
        check_eq("t4_hold_stable", ok, 32'd1);
        sample_ready_i = 1'b1;
        wait_frames(nd + 1, 100, "t4_frame_done");
        check_eq("t4_nsample", hs_cyc.size() - hb, 32'd2);
        check_eq("t4_ch1", ch_at(hb + 1), 32'd1);
        tick(3);

        // Overruns: three triggers while busy, one while disabled.
        channel_mask_i = 4'b1111;
        nd = n_done;
        pulse_trigger(t);
        tick(2);
        repeat (3) begin
            pulse_trigger(k);
            tick(2);
        end
        wait_frames(nd + 1, 200, "t5_frame_done");
        check_eq("t5_overrun", overrun_count_o, 32'd3);
        enable_i = 1'b0;
        sb = start_cyc.size();
        pulse_trigger(t);
        tick(3);
        check_eq("t5_disabled_overrun", overrun_count_o, 32'd3);
        check_eq("t5_disabled_nostart", start_cyc.size() - sb, 32'd0);
        enable_i = 1'b1;
        tick(2);

        // Empty mask.
        channel_mask_i = 4'b0000;
        sb = start_cyc.size(); nd = n_done;
        pulse_trigger(t);
        check_eq("t6_done_pulse", {30'd0, frame_done_o, busy_o}, 32'b10);
        tick(5);
        check_eq("t6_done_cyc", done_cyc, t + 1);
        check_eq("t6_ndone", n_done - nd, 32'd1);
        check_eq("t6_nostart", start_cyc.size() - sb, 32'd0);

        // Enable drops during the first transaction.
        channel_mask_i = 4'b1111;
        sb = start_cyc.size(); hb = hs_cyc.size(); nd = n_done;
        pulse_trigger(t);
        tick(2);
        enable_i = 1'b0;
        tick(30);
        check_eq("t7_nsample", hs_cyc.size() - hb, 32'd1);
        check_eq("t7_nstart", start_cyc.size() - sb, 32'd1);
        check_eq("t7_no_done", n_done - nd, 32'd0);
        check_eq("t7_idle", busy_o, 32'd0);
        enable_i = 1'b1;
        tick(2);

        // Reset in WAIT_DONE, then a clean frame.
        pulse_trigger(t);
        tick(2);
        tx = 32'(spi_tx_buffer_o);
        check_eq("t8_in_wait_done", {23'd0, busy_o, tx[7:0]}, 32'h110);
        reset_i = 1'b1;
        tick(1);
        check_eq("t8_rst_ctrl", {27'd0, spi_start_o, busy_o, sample_valid_o, frame_done_o, timeout_o}, 32'd0);
        check_eq("t8_rst_tx", spi_tx_buffer_o, 32'd0);
        check_eq("t8_rst_sample", {sample_channel_o, sample_data_o}, 32'd0);
        check_eq("t8_rst_overrun", overrun_count_o, 32'd0);
        reset_i = 1'b0;
        tick(10);
        sb = start_cyc.size(); hb = hs_cyc.size(); nd = n_done;
        pulse_trigger(t);
        wait_frames(nd + 1, 200, "t8_frame_done");
        check_eq("t8_nstart", start_cyc.size() - sb, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("t8_tx", tx_at(sb + i), 32'h10 + i);
            check_eq("t8_data", data_at(hb + i), 32'hDECA00 + i);
        end
        check_eq("t8_first_ch", ch_at(hb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Sequences the SPI master through a multi-channel ADC scan. Each scan frame starts on a trigger. For every enabled channel, the block waits for the ADC data-ready, issues one SPI transaction (8-bit command out, 24-bit result in) and presents the tagged sample on a valid/ready stream. It sits between the acquisition timing logic and the spi block, and is the only driver of the spi start_i and tx_buffer_i inputs.

Parameters:
NUM_CHANNELS, 4, number of ADC channels scanned (1..16).
CH_W, $clog2(NUM_CHANNELS) min 1, channel tag width.
CMD_BASE, 8'h10, command byte for channel 0; channel k sends CMD_BASE + k.
DRDY_TIMEOUT, 1000, clock cycles to wait for drdy_n_i low before skipping a channel.

Ports:
clock_i  in  1  system clock, all logic on rising edge.
reset_i  in  1  synchronous, active-high reset.
enable_i  in  1  scanning permitted; low blocks new frames.
trigger_i  in  1  one-cycle frame start request.
channel_mask_i  in  NUM_CHANNELS  enabled channels; latched at frame start.
drdy_n_i  in  1  ADC data-ready, active low, already synchronised.
spi_start_o  out  1  one-cycle start pulse to spi.
spi_tx_buffer_o  out  8  command byte to spi; stable from start until done.
spi_done_i  in  1  spi transaction complete (level).
spi_rx_buffer_i  in  24  spi received word, valid while spi_done_i high.
sample_valid_o  out  1  sample available.
sample_ready_i  in  1  downstream accepts.
sample_data_o  out  24  captured ADC word.
sample_channel_o  out  CH_W  channel tag of the sample.
busy_o  out  1  frame in progress.
frame_done_o  out  1  one-cycle pulse at end of a completed frame.
timeout_o  out  1  one-cycle pulse when a channel is skipped for DRDY timeout.
overrun_count_o  out  16  triggers dropped while busy; saturates at 16'hFFFF.

Behaviour:
- Reset: state IDLE. All outputs are 0 (spi_tx_buffer_o = 8'h00, overrun_count_o = 0). The mask latch, channel index and timeout counter are cleared. Reset takes effect on the next edge, including mid-transaction; the spi block is reset by the same reset_i.
- States:
  - IDLE: trigger_i & enable_i latches channel_mask_i, selects the lowest set bit, sets busy_o, and goes to WAIT_DRDY.
  - WAIT_DRDY: timeout counter runs. If drdy_n_i is low, go to START. If the counter reaches DRDY_TIMEOUT-1, pulse timeout_o and go to NEXT.
  - START: spi_start_o = 1 for exactly one cycle; spi_tx_buffer_o = CMD_BASE + channel (8-bit wrap); go to WAIT_DONE.
  - WAIT_DONE: completion is accepted only after spi_done_i has been observed low at least once since START (edge-qualified, so a stale done is ignored). On completion, register spi_rx_buffer_i and the channel and go to OUTPUT.
  - OUTPUT: sample_valid_o = 1, with data and channel held stable until sample_ready_i. The handshake completes in a cycle where valid and ready are both high; go to NEXT.
  - NEXT: clear the timeout counter. If there is a higher set mask bit and enable_i is high, select it and go to WAIT_DRDY. Otherwise go to IDLE: clear busy_o, and pulse frame_done_o only if enable_i is still high.
- Latency:
  - trigger at cycle T with drdy_n_i low gives spi_start_o at T+2.
  - qualified done at cycle D gives sample_valid_o at D+1.
  - valid & ready at cycle R, with next channel ready, gives the next spi_start_o at R+3.
- Empty mask: a trigger with channel_mask_i == 0 causes no SPI activity. busy_o stays 0 and frame_done_o pulses at T+1.
- trigger_i while busy_o = 1, or in the same cycle busy_o clears, is dropped and overrun_count_o increments (saturating).
- trigger_i while enable_i = 0 is ignored and not counted.
- enable_i falling mid-frame: the current SPI transaction and its output handshake complete; then the block returns to IDLE without frame_done_o.
- channel_mask_i changes mid-frame have no effect until the next frame.
- spi_tx_buffer_o holds its last value outside WAIT_DONE.

Decomposition:
- Package daq_pkg holds:
  - scan_state_t enum (IDLE, WAIT_DRDY, START, WAIT_DONE, OUTPUT, NEXT);
  - ADC_WORD_W = 24 and SPI_CMD_W = 8;
  - the default CMD_BASE constant.
- One sub-module, channel_picker: combinational. Given the mask and the current index, it returns the next set bit strictly above the index and a found flag (index of -1 selects the lowest bit).

Test Plan:
- Mask 4'b1111, drdy_n_i tied low, ADC model returns 24'hDECA00 + ch, ready always high -> four samples in order 0..3, tx bytes 8'h10..8'h13, data 24'hDECA00..24'hDECA03, one frame_done_o.
- Mask 4'b1010, drdy_n_i released 50 cycles after each start request -> only channels 1 and 3, tx 8'h11 then 8'h13, each spi_start_o no earlier than the drdy_n_i fall + 1.
- Mask 4'b0011, drdy_n_i held high on channel 0 -> timeout_o pulse after exactly 1000 cycles, no spi_start_o for ch0, then channel 1 sampled, frame_done_o pulses.
- sample_ready_i held low 20 cycles -> sample_valid_o, data and channel stable for 20 cycles, no new spi_start_o until the handshake.
- Three extra triggers during a frame -> overrun_count_o = 3. Mask 0 trigger -> frame_done_o at T+1 with no spi_start_o.
- reset_i asserted in WAIT_DONE -> all outputs 0 next cycle. A new trigger then yields a normal frame starting with channel 0.
